// File: rtl/ifetch_ctrl.sv
// Purpose : IF-stage fetch sequencer for a variable-latency IMEM (req/ready handshake).
// Latency : outputs are combinational from state and inputs; state and counters update on posedge clk.
// Backpres: hazard_stall parks an accepted response in HOLD; redirect overrides the stall and squashes stale responses.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   hazard_stall              decode cannot accept an instruction this cycle
//   redirect                  branch/jump resolved; the PC mux already selects the target
//   imem_ready                IMEM response valid for the outstanding request
//   imem_req                  request outstanding; IMEM samples the PC on its first cycle
//   pc_en / stall_pc          PC load strobe and its complement
//   ifid_valid                IF/ID captures the instruction
//   flush_decode              clear IF/ID, one pulse per accepted redirect
//   timeout_err               sticky; a request waited TIMEOUT cycles
//   fetch_count, stall_count  performance counters, present only with IFETCH_PERF_EN
//
// Optional feature macro: IFETCH_PERF_EN
module ifetch_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int TCW     = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_stall,
  input  logic        redirect,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic        stall_pc,
  output logic        pc_en,
  output logic        ifid_valid,
  output logic        flush_decode,
  output logic        timeout_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  localparam logic [TCW-1:0] TMO    = TCW'(TIMEOUT);
  localparam logic [TCW-1:0] TMO_M1 = TCW'(TIMEOUT - 1);

  state_t         state_q;
  state_t         state_d;
  logic [TCW-1:0] tcnt_q;
  logic           err_q;
  logic           waiting;
  logic           entering;

  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    pc_en        = 1'b0;
    ifid_valid   = 1'b0;
    flush_decode = 1'b0;
    // While rst is high, outputs are forced to their idle values so that
    // nothing leaks out of an in-flight request being abandoned.
    if (!rst) begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          imem_req = 1'b1;
          if (redirect) begin
            flush_decode = 1'b1;
            pc_en        = 1'b1;
            // Without a ready, IMEM still holds the old address, so the
            // response that eventually arrives must be thrown away.
            state_d      = imem_ready ? REQ : SQUASH;
          end else if (imem_ready && !hazard_stall) begin
            ifid_valid = 1'b1;
            pc_en      = 1'b1;
          end else if (imem_ready) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            flush_decode = 1'b1;
            pc_en        = 1'b1;
            state_d      = REQ;
          end else if (!hazard_stall) begin
            ifid_valid = 1'b1;
            pc_en      = 1'b1;
            state_d    = REQ;
          end
        end
        SQUASH: begin
          imem_req = 1'b1;
          if (redirect) begin
            flush_decode = 1'b1;
            pc_en        = 1'b1;
          end
          if (imem_ready) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
    stall_pc = ~pc_en;
  end

  // A request is still waiting when a request state sees no ready.
  assign waiting  = !rst && (state_q == REQ || state_q == SQUASH) && !imem_ready;
  // Entering REQ or SQUASH from another state starts a fresh wait window.
  assign entering = (state_d == REQ || state_d == SQUASH) && (state_d != state_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (imem_ready || entering) begin
        tcnt_q <= '0;
      end else if (waiting && tcnt_q != TMO) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      // Set on the same edge the counter arrives at TIMEOUT.
      if (waiting && !entering && tcnt_q == TMO_M1) begin
        err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = err_q;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      fetch_count <= fetch_count + 32'(ifid_valid);
      if (stall_pc && state_q != IDLE) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Purpose : directed self-checking bench for ifetch_ctrl.
// Latency : inputs driven on the falling edge; outputs sampled 1 ns later.
// Backpres: exercises hazard_stall holds, redirects, squashes and the request timeout.
module tb_ifetch_ctrl;

  logic clk = 1'b0;
  logic rst, hazard_stall, redirect, imem_ready;
  logic imem_req, stall_pc, pc_en, ifid_valid, flush_decode, timeout_err;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifetch_ctrl #(.TIMEOUT(255), .TCW(8)) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
    .imem_ready(imem_ready), .imem_req(imem_req), .stall_pc(stall_pc),
    .pc_en(pc_en), .ifid_valid(ifid_valid), .flush_decode(flush_decode),
    .timeout_err(timeout_err)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  // Observed output bundle: {imem_req, pc_en, ifid_valid, flush_decode, stall_pc}
  function automatic logic [4:0] outv();
    return {imem_req, pc_en, ifid_valid, flush_decode, stall_pc};
  endfunction

  // Drive one cycle's inputs on the falling edge, then settle.
  task automatic step(input logic r, input logic hs, input logic rd, input logic rdy);
    @(negedge clk);
    rst = r; hazard_stall = hs; redirect = rd; imem_ready = rdy;
    #1;
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 0, 0, 1);
    checks++; if (outv() !== 5'b00001) begin errors++; $display("FAIL reset_during: got %b want %b", outv(), 5'b00001); end
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b00001 || timeout_err !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b/%b want 00001/0", outv(), timeout_err); end
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL reset_to_req: got %b want %b", outv(), 5'b10001); end
  endtask

  task automatic test_stream();
    int nfetch = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      logic [4:0] exp;
      step(0, 0, 0, 1);
      exp = (i == 0) ? 5'b00001 : 5'b11100;
      nfetch += int'(ifid_valid);
      checks++; if (outv() !== exp) begin errors++; $display("FAIL stream_cyc%0d: got %b want %b", i, outv(), exp); end
    end
    checks++; if (nfetch !== 9) begin errors++; $display("FAIL stream_count: got %0d want 9", nfetch); end
`ifdef IFETCH_PERF_EN
    step(0, 0, 0, 0);
    checks++; if (fetch_count !== 32'd9 || stall_count !== 32'd0) begin errors++; $display("FAIL perf_counts: got %0d/%0d want 9/0", fetch_count, stall_count); end
`endif
  endtask

  task automatic test_hold();
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 1);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL hold_ready_stalled: got %b want %b", outv(), 5'b10001); end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0);
      checks++; if (outv() !== 5'b00001) begin errors++; $display("FAIL hold_wait%0d: got %b want %b", i, outv(), 5'b00001); end
    end
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b01100) begin errors++; $display("FAIL hold_release: got %b want %b", outv(), 5'b01100); end
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL hold_next_req: got %b want %b", outv(), 5'b10001); end
  endtask

  task automatic test_redirect();
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++; if (outv() !== 5'b11010) begin errors++; $display("FAIL redir_pulse: got %b want %b", outv(), 5'b11010); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL squash_wait: got %b want %b", outv(), 5'b10001); end
    step(0, 0, 0, 1);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL squash_drop: got %b want %b", outv(), 5'b10001); end
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    checks++; if (outv() !== 5'b11100) begin errors++; $display("FAIL redir_next_fetch: got %b want %b", outv(), 5'b11100); end
    // Redirect beats hazard_stall while a response is parked.
    step(0, 1, 0, 1);
    step(0, 1, 1, 0);
    checks++; if (outv() !== 5'b01010) begin errors++; $display("FAIL hold_redirect: got %b want %b", outv(), 5'b01010); end
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL hold_redirect_req: got %b want %b", outv(), 5'b10001); end
  endtask

  task automatic test_squash2();
    int nflush = 0;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    nflush += int'(flush_decode);
    step(0, 0, 1, 0);
    nflush += int'(flush_decode);
    checks++; if (outv() !== 5'b11010) begin errors++; $display("FAIL squash_redirect: got %b want %b", outv(), 5'b11010); end
    step(0, 0, 0, 1);
    nflush += int'(flush_decode);
    checks++; if (outv() !== 5'b10001) begin errors++; $display("FAIL squash2_drop: got %b want %b", outv(), 5'b10001); end
    checks++; if (nflush !== 2) begin errors++; $display("FAIL squash2_flushes: got %0d want 2", nflush); end
    step(0, 0, 0, 1);
    checks++; if (outv() !== 5'b11100) begin errors++; $display("FAIL squash2_fetch: got %b want %b", outv(), 5'b11100); end
    // Redirect and ready together inside SQUASH: flush and leave.
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    checks++; if (outv() !== 5'b11010) begin errors++; $display("FAIL squash_redir_ready: got %b want %b", outv(), 5'b11010); end
    step(0, 0, 0, 1);
    checks++; if (outv() !== 5'b11100) begin errors++; $display("FAIL squash_exit_fetch: got %b want %b", outv(), 5'b11100); end
  endtask

  task automatic test_timeout();
    do_reset();
    step(0, 0, 0, 0);
    // Wait cycle j sees j-1 completed waits; the flag appears once 255 have completed.
    for (int j = 1; j <= 256; j++) begin
      step(0, 0, 0, 0);
      if (j == 255) begin
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
      end
      if (j == 256) begin
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b want 1", timeout_err); end
      end
    end
    step(0, 0, 0, 1);
    checks++; if (outv() !== 5'b11100) begin errors++; $display("FAIL tmo_late_fetch: got %b want %b", outv(), 5'b11100); end
    step(0, 0, 0, 0);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    checks++; if (outv() !== 5'b00001 || timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_rst_clear: got %b/%b want 00001/0", outv(), timeout_err); end
  endtask

  initial begin
    rst = 1'b1; hazard_stall = 1'b0; redirect = 1'b0; imem_ready = 1'b0;
    test_reset();
    test_stream();
    test_hold();
    test_redirect();
    test_squash2();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
